// File: rtl/uop_pkg.sv
// uop_pkg: micro-op field layout, sequencing opcodes and sequencer states
package uop_pkg;
  localparam int SEQ_OP_MSB = 31;
  localparam int SEQ_OP_LSB = 28;
  localparam int TARGET_MSB = 27;
  localparam int TARGET_LSB = 20;
  localparam int PAYLOAD_W = 20;
  typedef enum logic [3:0] {OP_NEXT, OP_JUMP, OP_BRZ, OP_CALL, OP_RET, OP_HALT} seq_op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALTED} state_e;
endpackage

// File: rtl/uop_sequencer_if.sv
// uop_sequencer_if: ROM fetch port plus execute-unit issue/complete handshake
// master (sequencer): drives rom_addr, uop_valid, uop_bits; samples rom_data, uop_ready, exec_done, exec_zero
// slave (ROM + execute unit): the reverse
interface uop_sequencer_if #(parameter int UPC_W = 8);
  import uop_pkg::*;
  logic [UPC_W-1:0] rom_addr;
  logic [31:0] rom_data;
  logic uop_valid;
  logic uop_ready;
  logic [PAYLOAD_W-1:0] uop_bits;
  logic exec_done;
  logic exec_zero;
  modport master (output rom_addr, uop_valid, uop_bits, input rom_data, uop_ready, exec_done, exec_zero);
  modport slave (input rom_addr, uop_valid, uop_bits, output rom_data, uop_ready, exec_done, exec_zero);
endinterface

// File: rtl/uop_return_stack.sv
// uop_return_stack: LIFO of return micro-PCs, top entry always held in slot 0
// ports: clk, reset (async active-low), clr (empty), push/din, pop, top, full, empty
module uop_return_stack #(parameter int DEPTH = 4, parameter int W = 8) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic full,
  output logic empty
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  assign top = r_mem[0];
  assign full = r_cnt == CW'(DEPTH);
  assign empty = r_cnt == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clr) r_cnt <= '0;
    else if (push && !full) begin
      r_cnt <= r_cnt + 1'b1;
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end else if (pop && !empty) begin
      r_cnt <= r_cnt - 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
    end
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: micro-PC controller fetching micro-ops from ROM and issuing payloads to the execute unit
// ports: clk, reset (async active-low), start/start_addr, bus (uop_sequencer_if.master), upc, busy, halted, err
// UOP_STACK_EN: adds a STACK_DEPTH-entry return stack for CALL/RET; without it CALL acts as JUMP and RET is illegal
module uop_sequencer import uop_pkg::*; #(parameter int UPC_W = 8, parameter int STACK_DEPTH = 4) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [UPC_W-1:0] start_addr,
  uop_sequencer_if.master bus,
  output logic [UPC_W-1:0] upc,
  output logic busy,
  output logic halted,
  output logic err
);
  state_e r_state;
  logic [31:0] r_uop;
  logic [UPC_W-1:0] r_upc;
  logic r_err;
  logic [3:0] w_fop, w_op;
  logic [UPC_W-1:0] w_inc, w_tgt;
  logic w_ill, w_go, w_hs;
  assign w_fop = bus.rom_data[SEQ_OP_MSB:SEQ_OP_LSB];
  assign w_op = r_uop[SEQ_OP_MSB:SEQ_OP_LSB];
  assign w_inc = r_upc + UPC_W'(1);
  assign w_tgt = r_uop[TARGET_LSB +: UPC_W];
  assign w_go = start && (r_state == S_IDLE || r_state == S_HALTED);
  assign w_hs = r_state == S_ISSUE && bus.uop_ready;
`ifdef UOP_STACK_EN
  logic w_full, w_empty;
  logic [UPC_W-1:0] w_top;
  assign w_ill = w_fop > OP_HALT;
  uop_return_stack #(.DEPTH(STACK_DEPTH), .W(UPC_W)) u_stack (
    .clk(clk), .reset(reset), .clr(w_go),
    .push(w_hs && w_op == OP_CALL), .pop(w_hs && w_op == OP_RET),
    .din(w_inc), .top(w_top), .full(w_full), .empty(w_empty)
  );
`else
  assign w_ill = w_fop > OP_HALT || w_fop == OP_RET;
`endif
  assign bus.rom_addr = r_upc;
  assign bus.uop_valid = r_state == S_ISSUE;
  assign bus.uop_bits = r_uop[PAYLOAD_W-1:0];
  assign upc = r_upc;
  assign busy = r_state == S_FETCH || r_state == S_ISSUE || r_state == S_WAIT;
  assign halted = r_state == S_HALTED;
  assign err = r_err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_uop <= '0;
      r_upc <= '0;
      r_err <= 1'b0;
    end else if (w_go) begin
      r_upc <= start_addr;
      r_err <= 1'b0;
      r_state <= S_FETCH;
    end else
      case (r_state)
        S_FETCH: begin
          r_uop <= bus.rom_data;
          r_state <= (w_ill || w_fop == OP_HALT) ? S_HALTED : S_ISSUE;
          if (w_ill) r_err <= 1'b1;
        end
        S_ISSUE: if (w_hs) begin
          r_state <= S_FETCH;
          case (w_op)
            OP_JUMP: r_upc <= w_tgt;
            OP_BRZ: r_state <= S_WAIT;
`ifdef UOP_STACK_EN
            OP_CALL: if (w_full) begin
              r_state <= S_HALTED;
              r_err <= 1'b1;
            end else r_upc <= w_tgt;
            OP_RET: if (w_empty) begin
              r_state <= S_HALTED;
              r_err <= 1'b1;
            end else r_upc <= w_top;
`else
            OP_CALL: r_upc <= w_tgt;
`endif
            default: r_upc <= w_inc;
          endcase
        end
        S_WAIT: if (bus.exec_done) begin
          r_upc <= bus.exec_zero ? w_tgt : w_inc;
          r_state <= S_FETCH;
        end
        default: ;
      endcase
endmodule

// File: doc/uop_sequencer.md
# uop_sequencer

Micro-PC controller that sequences `microcode_exec`: fetches 32-bit micro-ops from the microcode ROM, issues their payload to the execute unit over a valid/ready handshake, and computes the next micro-PC (sequential, jump, zero-flag branch, call/return, halt). It sits between the microcode ROM and `microcode_exec`, replacing the bench-driven whole-array load with a real fetch/issue loop.

## Interface
- `UPC_W`, 8: micro-PC width; ROM depth is 2^UPC_W words.
- `STACK_DEPTH`, 4: return-stack entries (used only with `UOP_STACK_EN`).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse: begin execution at `start_addr`; honoured only in IDLE or HALTED.
- `start_addr`  in  UPC_W  entry micro-PC.
- `rom_addr`  out  UPC_W  ROM read address; combinational ROM read.
- `rom_data`  in  32  micro-op at `rom_addr`, same cycle.
- `uop_valid`  out  1  payload valid to execute unit.
- `uop_ready`  in  1  execute unit accepts payload.
- `uop_bits`  out  20  payload, `rom_data[19:0]` of current uop.
- `exec_done`  in  1  execute unit finished last accepted uop; `exec_zero` valid this cycle.
- `exec_zero`  in  1  zero flag of last completed uop.
- `upc`  out  UPC_W  current micro-PC.
- `busy`  out  1  state is FETCH, ISSUE or WAIT.
- `halted`  out  1  state is HALTED.
- `err`  out  1  sticky error; set on illegal op or stack fault.

## Operation
- Uop format: `[31:28]` seq op, `[27:20]` target (low UPC_W bits used), `[19:0]` payload.
- Seq ops: 0 NEXT, 1 JUMP, 2 BRZ, 3 CALL, 4 RET, 5 HALT; 6–15 illegal.
- States: IDLE, FETCH, ISSUE, WAIT, HALTED.
- IDLE/HALTED + `start`: `upc`<=`start_addr`, `err`<=0, stack emptied, -> FETCH.
- FETCH: `rom_addr`=`upc`; latch uop into register. HALT -> HALTED (not issued). Illegal -> HALTED, `err`=1 (not issued). Else -> ISSUE.
- ISSUE: `uop_valid`=1, `uop_bits` stable until `uop_valid && uop_ready`. On handshake: BRZ -> WAIT; others compute next PC and -> FETCH.
- Next PC: NEXT `upc+1` mod 2^UPC_W (wrap 2^UPC_W-1 -> 0); JUMP target; CALL push `upc+1`, then target; RET pop.
- WAIT: hold until `exec_done`; then `exec_zero` ? target : `upc+1`; -> FETCH. `exec_done` outside WAIT ignored.
- Stack faults: CALL with stack full or RET with stack empty -> uop still issued, then HALTED with `err`=1, `upc` unchanged.
- `start` while busy: ignored.

## Timing
- Reset values: `upc`=0, state IDLE, `uop_valid`=0, `uop_bits`=0, `busy`=0, `halted`=0, `err`=0, stack empty, `rom_addr`=0.
- Reset assertion mid-transfer drops `uop_valid` immediately (asynchronous); no partial update survives.
- `start` sampled at edge N: FETCH in N+1, `uop_valid` high from N+2.
- Non-branch uop with `uop_ready` tied high: 2 cycles per uop (FETCH, ISSUE).
- BRZ: ISSUE, then WAIT ≥1 cycle; next FETCH the cycle after `exec_done`.
- HALT: `halted` high the cycle after the FETCH of the HALT uop.

## Configuration
- `UOP_STACK_EN` defined: return stack of `STACK_DEPTH` entries; CALL/RET as above.
- Not defined: no stack storage; CALL behaves as JUMP; RET treated as illegal (not issued, HALTED, `err`=1).

## Structure
- Package `uop_pkg`: seq-op enum, field bit positions (`SEQ_OP_MSB/LSB`, `TARGET_MSB/LSB`, `PAYLOAD_W`=20), state enum.
- Sub-module `uop_return_stack` (push/pop/full/empty, depth parameter), instantiated only under `UOP_STACK_EN`.

## Test plan
- ROM 0:NEXT,1:NEXT,2:HALT; `start_addr`=0, `uop_ready`=1 -> payloads of 0,1 issued at cycles 2,4; `halted`=1, `upc`=2, `err`=0.
- 0:BRZ target 0x10; `exec_done` with `exec_zero`=1 after 3 cycles -> next FETCH at 0x10; repeat with `exec_zero`=0 -> FETCH at 1.
- `uop_ready` held low 5 cycles in ISSUE -> `uop_valid` and `uop_bits` stable all 5 cycles; single issue on ready.
- 0:CALL 0x20, 0x20:RET, 1:HALT (`UOP_STACK_EN`) -> PC sequence 0,0x20,1; 5 nested CALLs at depth 4 -> HALTED, `err`=1.
- NEXT at `upc`=0xFF -> next FETCH at 0x00; opcode 0x7 -> HALTED, `err`=1, no `uop_valid`.
- `reset` low during ISSUE -> `uop_valid`=0 same cycle, `upc`=0, IDLE; `start` after release runs normally.
